// File: rtl/bitstream_tx_scheduler_if.sv
// Bundle between byte producers and the shared-serializer scheduler.
//
// Handshake: a byte of requester i moves on a rising clk edge where both
// req_valid[i] and req_ready[i] are 1. req_ready does not depend on
// req_valid, and a producer holds data/last stable while valid waits.
// ser_valid is a one-cycle load pulse with no back-pressure; ser_data holds
// its value between pulses.
interface bitstream_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int BYTE_W  = 8
);
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [BYTE_W-1:0]         ser_data;
    logic                      ser_valid;
    logic [NUM_REQ-1:0]        grant;
    logic                      frame_active;
    logic [15:0]               frame_count;
    logic [1:0]                dbg_state;

    modport master (
        output req_data, req_valid, req_last,
        input  req_ready, ser_data, ser_valid, grant, frame_active,
               frame_count, dbg_state
    );

    modport slave (
        input  req_data, req_valid, req_last,
        output req_ready, ser_data, ser_valid, grant, frame_active,
               frame_count, dbg_state
    );
endinterface

// File: rtl/bitstream_tx_scheduler.sv
// Round-robin, frame-locked scheduler feeding one byte serializer.
// A granted requester keeps the serializer until it hands over a byte
// marked last; loads are spaced BYTE_W+GAP cycles apart within a frame.
module bitstream_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int BYTE_W  = 8,
    parameter int GAP     = 0
) (
    input logic                     clk,
    input logic                     rst,
    bitstream_tx_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SPAN  = BYTE_W + GAP;
    localparam int CNT_W = $clog2(SPAN + 1);
    // WAIT runs SPAN-1 cycles; together with the LOAD cycle that gives SPAN.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SPAN - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant_r;
    logic               locked;
    logic               last_r;
    logic [CNT_W-1:0]   cnt;
    logic [BYTE_W-1:0]  ser_data_r;
    logic               ser_valid_r;
    logic [15:0]        frame_count_r;

    logic [IDX_W:0]     rr_sum;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [BYTE_W-1:0]  cur_data;
    logic               cur_valid;
    logic               cur_last;
    logic [NUM_REQ-1:0] ready_v;
    logic [NUM_REQ-1:0] grant_v;
    logic [IDX_W-1:0]   next_ptr;

    // Round-robin pick: first valid requester at or after ptr, wrapping.
    always_comb begin
        rr_sum    = '0;
        rr_idx    = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
            end
            rr_idx = rr_sum[IDX_W-1:0];
            if (!sel_found && bus.req_valid[rr_idx]) begin
                sel_found = 1'b1;
                sel_idx   = rr_idx;
            end
        end
    end

    // Owner mux and one-hot decodes of the current grant.
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        ready_v   = '0;
        grant_v   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_r == IDX_W'(i)) begin
                cur_data   = bus.req_data[i*BYTE_W +: BYTE_W];
                cur_valid  = bus.req_valid[i];
                cur_last   = bus.req_last[i];
                ready_v[i] = (state == LOAD);
                grant_v[i] = (state != IDLE);
            end
        end
    end

    assign next_ptr = (grant_r == IDX_W'(NUM_REQ - 1)) ? '0 : grant_r + 1'b1;

    // Main FSM: arbitration, byte loads, inter-byte spacing, frame counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= '0;
            grant_r       <= '0;
            locked        <= 1'b0;
            last_r        <= 1'b0;
            cnt           <= '0;
            ser_data_r    <= '0;
            ser_valid_r   <= 1'b0;
            frame_count_r <= '0;
        end else begin
            ser_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_r <= sel_idx;
                        locked  <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (cur_valid) begin
                        ser_data_r  <= cur_data;
                        ser_valid_r <= 1'b1;
                        last_r      <= cur_last;
                        locked      <= 1'b1;
                        cnt         <= CNT_LOAD;
                        state       <= WAIT;
                    end else if (!locked) begin
                        // Withdrawn before the first byte: ptr is left alone.
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (last_r) begin
                            state         <= IDLE;
                            ptr           <= next_ptr;
                            frame_count_r <= frame_count_r + 16'd1;
                        end else begin
                            state <= LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = ready_v;
    assign bus.grant        = grant_v;
    assign bus.frame_active = (state != IDLE);
    assign bus.ser_data     = ser_data_r;
    assign bus.ser_valid    = ser_valid_r;
    assign bus.frame_count  = frame_count_r;
    assign bus.dbg_state    = state;
endmodule

// File: doc/bitstream_tx_scheduler.md
# bitstream_tx_scheduler

Shares one `byte_to_bitstream` serializer among `NUM_REQ` byte sources. It runs a round-robin arbiter with frame locking: a granted requester keeps the serializer until it hands over a byte marked `last`. Bytes are issued to the serializer as single-cycle load pulses, spaced so that each byte's bits finish before the next load. The block sits between the packet/byte producers and the serializer's `data_in`/`data_in_valid` inputs.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `BYTE_W`, default 8: bits per byte; equals the serializer's shift length.
- `GAP`, default 0: extra idle bit-cycles inserted between bytes. `BYTE_W+GAP` must be at least 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset; 0 clears all state immediately.
- `req_data`, in, `NUM_REQ*BYTE_W`: byte of requester i at `[i*BYTE_W +: BYTE_W]`.
- `req_valid`, in, `NUM_REQ`: requester i has a byte pending.
- `req_last`, in, `NUM_REQ`: the pending byte of requester i ends its frame.
- `req_ready`, out, `NUM_REQ`: byte of requester i is taken this cycle when `req_valid[i]`=1.
- `ser_data`, out, `BYTE_W`: byte to the serializer `data_in`.
- `ser_valid`, out, 1: one-cycle load pulse to the serializer `data_in_valid`.
- `grant`, out, `NUM_REQ`: one-hot current owner; 0 when idle.
- `frame_active`, out, 1: high whenever the state is not IDLE.
- `frame_count`, out, 16: completed frames; wraps from 0xFFFF to 0.

## Operation
State machine with three states: IDLE, LOAD and WAIT.

- **IDLE**
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise select the first requester with `req_valid`=1, searching from `ptr` upward and wrapping modulo `NUM_REQ`.
  - Register it as `grant_r`, clear the `locked` flag, and go to LOAD.
- **LOAD**
  - `req_ready[i] = (state==LOAD) && (grant_r==i)`. This is combinational; all other `req_ready` bits are 0.
  - If `req_valid[grant_r]`=1:
    - Register `ser_data`.
    - Pulse `ser_valid` on the next cycle.
    - Set `last_r` to `req_last[grant_r]`, set `locked` to 1, and set `cnt` to `BYTE_W+GAP-2`.
    - Go to WAIT.
  - If `req_valid[grant_r]`=0 and `locked`=1, stay in LOAD. The grant is held mid-frame.
  - If `req_valid[grant_r]`=0 and `locked`=0, return to IDLE. The requester withdrew before its first byte; `ptr` is unchanged.
- **WAIT**
  - `cnt` decrements each cycle.
  - When `cnt`=0 and `last_r`=1:
    - Go to IDLE.
    - Set `ptr` to `(grant_r+1) mod NUM_REQ`.
    - Increment `frame_count`.
  - When `cnt`=0 and `last_r`=0, go to LOAD.
- `grant` is the one-hot decode of `grant_r` while the state is not IDLE, and 0 in IDLE.
- `ser_data` holds its value between loads.
- Reset values: state IDLE, `ptr`=0, `grant_r`=0, `locked`=0, `last_r`=0, `cnt`=0, `ser_data`=0, `ser_valid`=0, `frame_count`=0.
  - Combinational outputs in reset: `req_ready`=0, `grant`=0, `frame_active`=0.
- Reset asserted mid-operation: all state clears asynchronously, including an in-flight `ser_valid`. No byte is handed over during reset. The current frame is abandoned and not counted.
- A single-byte frame (`last`=1 on the first byte) is legal and counts as one frame.
- If a requester asserts `req_valid` without holding the grant, it waits; it is never starved, by round-robin order.

## Timing
- Request to load: requester valid in IDLE at cycle N, LOAD at N+1 (`req_ready` high), `ser_valid` high at N+2.
- Within a frame, consecutive `ser_valid` pulses are exactly `BYTE_W+GAP` cycles apart, provided the requester keeps valid high.
- From the last byte's `ser_valid` to the next frame's first `ser_valid`: `BYTE_W+GAP+1` cycles, because IDLE adds one arbitration cycle.
- `ser_valid` is never high two cycles in a row.
- `frame_count` updates on the cycle WAIT exits to IDLE.

## Test plan
- **Reset:** drive `rst`=0 with random inputs.
  - Required: all outputs 0.
  - Release `rst`, then raise `req_valid[2]` with `req_last`=1 and byte 0xAA. Required: `grant`=0b0100, `ser_valid` 2 cycles after valid with `ser_data`=0xAA, `frame_count`=1.
- **Multi-byte frame:** `NUM_REQ`=4, `GAP`=0; requester 1 sends frame 0x0F, 0x55, 0xC3 (last on 0xC3); requester 0 is continuously valid.
  - Required: three `ser_valid` pulses 8 cycles apart with the bytes in order.
  - Requester 0 is granted only after the frame; its first pulse comes 9 cycles after 0xC3.
- **Round-robin:** all four requesters valid, each sending single-byte frames.
  - Required grant order after reset: 0, 1, 2, 3, 0.
  - `frame_count` is 5 after five frames.
- **Mid-frame stall:** requester 3 drops valid for 20 cycles after its first byte.
  - Required: `grant` stays 0b1000 and no `ser_valid` occurs during the stall.
  - On resume, `req_ready[3]` is high in the same cycle and the byte is loaded on the next cycle.
- **Withdrawal:** requester 1 pulses valid for one cycle only, in IDLE.
  - Required: back to IDLE with no `ser_valid`; `ptr` is unchanged, so requester 0 still wins the next tie against 1.
- **Async reset mid-frame and GAP:**
  - Assert `rst` during WAIT. Required: `ser_valid`, `grant` and `frame_active` drop to 0 immediately; the next frame starts from `ptr`=0.
  - Separate run with `GAP`=2. Required: pulse spacing is 10 cycles.
